usb_rx_nrzi_unstuff: RTL and testbench
======================================

Name: usb_rx_nrzi_unstuff

Overview:
- Parametrised successor to the receive-side NRZI decoder.
- Samples the differential pair on each shift_enable strobe and classifies the line state (J/K/SE0/SE1).
- NRZI-decodes J/K samples, removes stuffed bits, flags stuffing errors, and detects EOP and SE0 framing faults.
- Sits between the edge-sync/timer block and the RX shift register and RX control FSM.

Parameters:
- STUFF_LEN, 6, run length of decoded 1s after which the next bit must be a stuffed 0 (range 2..15).
- EOP_SE0_BITS, 2, minimum SE0 samples before J that form a valid EOP (range 1..7).
- LOW_SPEED, 0, line mode: 0 = full speed (J is d_plus=1, d_minus=0); 1 = low speed (J is d_plus=0, d_minus=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- d_plus  in  1  synchronised D+ line
- d_minus  in  1  synchronised D- line
- shift_enable  in  1  one-cycle bit-sample strobe from the bit timer
- d_orig  out  1  decoded data bit; qualified by d_valid
- d_valid  out  1  one-cycle pulse: d_orig holds a new, non-stuffed data bit
- unstuffed  out  1  one-cycle pulse: a stuffed 0 was removed
- stuff_err  out  1  one-cycle pulse: STUFF_LEN+1 consecutive 1s seen
- eop  out  1  one-cycle pulse: valid EOP (at least EOP_SE0_BITS SE0 samples, then J)
- se0_err  out  1  one-cycle pulse: SE0 run too short, or SE0 followed by K
- se1_err  out  1  one-cycle pulse: SE1 sampled

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Internal reset values: prev_level=J, ones_cnt=0, se0_cnt=0, state=DATA.
- Latency: an event on the sample taken at shift_enable cycle N appears on outputs in cycle N+1. Every pulse output is low in all other cycles.
- No processing occurs in cycles where shift_enable=0; internal state holds.
- Classification per LOW_SPEED:
  - J or K per the mode definition above.
  - SE0 = both lines 0.
  - SE1 = both lines 1.
- FSM states: DATA, SE0_RUN.
- DATA, J/K sample:
  - Decoded bit b = (level == prev_level); then prev_level <= level.
  - If ones_cnt == STUFF_LEN:
    - b=0: unstuffed=1, d_valid=0, ones_cnt <= 0.
    - b=1: stuff_err=1, d_valid=0, ones_cnt <= 0.
  - Otherwise: d_orig=b, d_valid=1; ones_cnt <= b ? ones_cnt+1 : 0.
- DATA, SE0 sample: se0_cnt <= 1, go to SE0_RUN. No data output.
- SE0_RUN, SE0 sample: se0_cnt increments, saturating at 7.
- SE0_RUN, J sample:
  - se0_cnt >= EOP_SE0_BITS: eop=1. Otherwise: se0_err=1.
  - In both cases: prev_level <= J, ones_cnt <= 0, se0_cnt <= 0, go to DATA. No d_valid.
- SE0_RUN, K sample: se0_err=1, prev_level <= K, ones_cnt <= 0, se0_cnt <= 0, go to DATA.
- SE1 in any state: se1_err=1. prev_level, ones_cnt, se0_cnt and state are unchanged.
- ones_cnt width is $clog2(STUFF_LEN+1). se0_cnt is 3 bits.
- Asserting rst mid-packet immediately clears all state and outputs. After release, the first J/K sample decodes relative to J.
- At most one of d_valid, unstuffed, stuff_err, eop, se0_err, se1_err is high in any cycle.

Decomposition:
- Package usb_rx_pkg holds:
  - line_state_t enum {LS_J, LS_K, LS_SE0, LS_SE1}.
  - rx_dec_state_t enum {DATA, SE0_RUN}.
  - Constants USB_STUFF_LEN=6 and USB_EOP_SE0_BITS=2, used as parameter defaults.
- One sub-module, usb_line_classify: combinational; parameter LOW_SPEED; inputs d_plus and d_minus; output line_state_t.
- The top level contains the FSM, counters and output registers.

Test Plan:
- Sync pattern KJKJKJKK (FS) after reset -> d_valid pulses decode 0,0,0,0,0,0,0,1. No error pulses.
- Seven J samples after a K (six decoded 1s), then a K -> six d_valid with d_orig=1, then unstuffed=1 with d_valid=0. The next J/K sample decodes normally.
- Seven consecutive decoded 1s -> six d_valid, then stuff_err=1 on the seventh. ones_cnt is cleared, so the eighth 1 gives d_valid=1.
- SE0,SE0,J -> eop=1 exactly one cycle after the J sample. A following K decodes as 0.
- SE0,J with EOP_SE0_BITS=2 -> se0_err=1, no eop. SE0,K -> se0_err=1.
- LOW_SPEED=1: d_minus=1/d_plus=0 (J) run with a K, using stimulus mirrored from scenario 1 -> identical decoded bits. SE1 mid-stream -> se1_err=1, and the next bit decodes against the pre-SE1 level.
- rst asserted mid-stream with ones_cnt=5 -> all outputs 0 immediately. After release, six decoded 1s produce no unstuffed or stuff_err before the seventh bit.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// ============================================================================
// Module   : usb_rx_pkg
// Purpose  : Shared types and default constants for the USB receive decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_t;

  typedef enum logic {
    DATA    = 1'b0,
    SE0_RUN = 1'b1
  } rx_dec_state_t;

  localparam int USB_STUFF_LEN    = 6;
  localparam int USB_EOP_SE0_BITS = 2;

endpackage

`default_nettype wire

// File: rtl/usb_line_classify.sv
// ============================================================================
// Module   : usb_line_classify
// Purpose  : Maps the synchronised D+/D- pair onto J/K/SE0/SE1 for the line speed.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_line_classify
  import usb_rx_pkg::*;
#(
  parameter int LOW_SPEED = 0
) (
  input  logic        d_plus,
  input  logic        d_minus,
  output line_state_t line_state
);

  localparam bit C_LOW_SPEED = (LOW_SPEED != 0);

  // Low speed swaps the idle polarity, so J and K trade places.
  always_comb begin
    line_state = LS_SE0;
    case ({d_plus, d_minus})
      2'b00:   line_state = LS_SE0;
      2'b11:   line_state = LS_SE1;
      2'b10:   line_state = C_LOW_SPEED ? LS_K : LS_J;
      2'b01:   line_state = C_LOW_SPEED ? LS_J : LS_K;
      default: line_state = LS_SE0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/usb_rx_nrzi_unstuff.sv
// ============================================================================
// Module   : usb_rx_nrzi_unstuff
// Purpose  : NRZI decode, bit unstuffing, EOP and SE0/SE1 fault detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN    = USB_STUFF_LEN,
  parameter int EOP_SE0_BITS = USB_EOP_SE0_BITS,
  parameter int LOW_SPEED    = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic shift_enable,
  output logic d_orig,
  output logic d_valid,
  output logic unstuffed,
  output logic stuff_err,
  output logic eop,
  output logic se0_err,
  output logic se1_err
);

  localparam int              C_ONES_W   = $clog2(STUFF_LEN + 1);
  localparam logic [C_ONES_W-1:0] C_STUFF = C_ONES_W'(STUFF_LEN);
  localparam logic [2:0]      C_EOP_MIN  = 3'(EOP_SE0_BITS);
  localparam logic [2:0]      C_SE0_SAT  = 3'd7;

  line_state_t          line_state;
  rx_dec_state_t        state, state_nxt;
  line_state_t          prev_level, prev_level_nxt;
  logic [C_ONES_W-1:0]  ones_cnt, ones_cnt_nxt;
  logic [2:0]           se0_cnt, se0_cnt_nxt;
  logic                 bit_val;
  logic                 d_orig_nxt, d_valid_nxt, unstuffed_nxt, stuff_err_nxt;
  logic                 eop_nxt, se0_err_nxt, se1_err_nxt;

  usb_line_classify #(
    .LOW_SPEED (LOW_SPEED)
  ) u_classify (
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .line_state (line_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DATA;
      prev_level <= LS_J;
      ones_cnt   <= '0;
      se0_cnt    <= '0;
      d_orig     <= 1'b0;
      d_valid    <= 1'b0;
      unstuffed  <= 1'b0;
      stuff_err  <= 1'b0;
      eop        <= 1'b0;
      se0_err    <= 1'b0;
      se1_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_level <= prev_level_nxt;
      ones_cnt   <= ones_cnt_nxt;
      se0_cnt    <= se0_cnt_nxt;
      d_orig     <= d_orig_nxt;
      d_valid    <= d_valid_nxt;
      unstuffed  <= unstuffed_nxt;
      stuff_err  <= stuff_err_nxt;
      eop        <= eop_nxt;
      se0_err    <= se0_err_nxt;
      se1_err    <= se1_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_level_nxt = prev_level;
    ones_cnt_nxt   = ones_cnt;
    se0_cnt_nxt    = se0_cnt;
    d_orig_nxt     = d_orig;
    d_valid_nxt    = 1'b0;
    unstuffed_nxt  = 1'b0;
    stuff_err_nxt  = 1'b0;
    eop_nxt        = 1'b0;
    se0_err_nxt    = 1'b0;
    se1_err_nxt    = 1'b0;
    bit_val        = 1'b0;

    if (shift_enable) begin
      case (line_state)
        // SE1 is flagged but otherwise invisible to the decoder.
        LS_SE1: se1_err_nxt = 1'b1;

        LS_SE0: begin
          if (state == DATA) begin
            se0_cnt_nxt = 3'd1;
            state_nxt   = SE0_RUN;
          end else if (se0_cnt != C_SE0_SAT) begin
            se0_cnt_nxt = se0_cnt + 3'd1;
          end
        end

        default: begin
          if (state == SE0_RUN) begin
            if (line_state == LS_J && se0_cnt >= C_EOP_MIN) begin
              eop_nxt = 1'b1;
            end else begin
              se0_err_nxt = 1'b1;
            end
            prev_level_nxt = line_state;
            ones_cnt_nxt   = '0;
            se0_cnt_nxt    = '0;
            state_nxt      = DATA;
          end else begin
            bit_val        = (line_state == prev_level);
            prev_level_nxt = line_state;
            if (ones_cnt == C_STUFF) begin
              // This slot must carry the stuffed 0; a 1 here is a violation.
              unstuffed_nxt = ~bit_val;
              stuff_err_nxt = bit_val;
              ones_cnt_nxt  = '0;
            end else begin
              d_orig_nxt   = bit_val;
              d_valid_nxt  = 1'b1;
              ones_cnt_nxt = bit_val ? ones_cnt + C_ONES_W'(1) : '0;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_nrzi_unstuff.sv
// ============================================================================
// Module   : tb_usb_rx_nrzi_unstuff
// Purpose  : Directed bench; full-speed and mirrored low-speed instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usb_rx_nrzi_unstuff;

  // Line values as {d_plus, d_minus} in full-speed terms.
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b11;

  // Expected {d_orig&d_valid, d_valid, unstuffed, stuff_err, eop, se0_err, se1_err}.
  localparam logic [6:0] NONE = 7'b0_000000;
  localparam logic [6:0] D0   = 7'b0_100000;
  localparam logic [6:0] D1   = 7'b1_100000;
  localparam logic [6:0] UNS  = 7'b0_010000;
  localparam logic [6:0] SERR = 7'b0_001000;
  localparam logic [6:0] EOP  = 7'b0_000100;
  localparam logic [6:0] SE0E = 7'b0_000010;
  localparam logic [6:0] SE1E = 7'b0_000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic shift_enable = 1'b0;
  logic fs_dp = 1'b1, fs_dm = 1'b0;
  logic ls_dp = 1'b0, ls_dm = 1'b1;

  logic fs_d_orig, fs_d_valid, fs_uns, fs_serr, fs_eop, fs_se0e, fs_se1e;
  logic ls_d_orig, ls_d_valid, ls_uns, ls_serr, ls_eop, ls_se0e, ls_se1e;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  usb_rx_nrzi_unstuff #(.STUFF_LEN(6), .EOP_SE0_BITS(2), .LOW_SPEED(0)) u_fs (
    .clk(clk), .rst(rst), .d_plus(fs_dp), .d_minus(fs_dm), .shift_enable(shift_enable),
    .d_orig(fs_d_orig), .d_valid(fs_d_valid), .unstuffed(fs_uns), .stuff_err(fs_serr),
    .eop(fs_eop), .se0_err(fs_se0e), .se1_err(fs_se1e)
  );

  usb_rx_nrzi_unstuff #(.STUFF_LEN(6), .EOP_SE0_BITS(2), .LOW_SPEED(1)) u_ls (
    .clk(clk), .rst(rst), .d_plus(ls_dp), .d_minus(ls_dm), .shift_enable(shift_enable),
    .d_orig(ls_d_orig), .d_valid(ls_d_valid), .unstuffed(ls_uns), .stuff_err(ls_serr),
    .eop(ls_eop), .se0_err(ls_se0e), .se1_err(ls_se1e)
  );

  logic [6:0] fs_obs, ls_obs;
  assign fs_obs = {fs_d_orig & fs_d_valid, fs_d_valid, fs_uns, fs_serr, fs_eop, fs_se0e, fs_se1e};
  assign ls_obs = {ls_d_orig & ls_d_valid, ls_d_valid, ls_uns, ls_serr, ls_eop, ls_se0e, ls_se1e};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ln);
    fs_dp = ln[1];
    fs_dm = ln[0];
    ls_dp = ln[0];
    ls_dm = ln[1];
  endtask

  // One sample strobe; outputs are checked in the following cycle on both instances.
  task automatic step(input logic [1:0] ln, input logic [6:0] exp, input string tag);
    @(negedge clk);
    drive(ln);
    shift_enable = 1'b1;
    @(posedge clk);
    #1;
    shift_enable = 1'b0;
    chk({"fs_", tag}, fs_obs, exp);
    chk({"ls_", tag}, ls_obs, exp);
  endtask

  // A cycle with a live line but no strobe must leave every pulse low.
  task automatic idle(input logic [1:0] ln, input string tag);
    @(negedge clk);
    drive(ln);
    shift_enable = 1'b0;
    @(posedge clk);
    #1;
    chk({"fs_", tag}, fs_obs, NONE);
    chk({"ls_", tag}, ls_obs, NONE);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("fs_reset", fs_obs, NONE);
    chk("ls_reset", ls_obs, NONE);
    @(negedge clk);
    rst = 1'b0;

    // Sync pattern KJKJKJKK
    step(LK, D0, "sync0"); step(LJ, D0, "sync1"); step(LK, D0, "sync2"); step(LJ, D0, "sync3");
    step(LK, D0, "sync4"); step(LJ, D0, "sync5"); step(LK, D0, "sync6"); step(LK, D1, "sync7");
    idle(LJ, "idle_a");

    // Six decoded 1s then a stuffed 0
    step(LK, D1, "pre_k");
    step(LJ, D0, "pre_j");
    step(LK, D0, "lead_k");
    step(LJ, D0, "first_j");
    for (int i = 0; i < 6; i++) step(LJ, D1, $sformatf("ones%0d", i));
    step(LK, UNS, "unstuff");
    step(LK, D1, "after_unstuff");

    // Seven decoded 1s: stuff error, then the counter restarts
    step(LJ, D0, "serr_lead");
    for (int i = 0; i < 6; i++) step(LJ, D1, $sformatf("serr_ones%0d", i));
    step(LJ, SERR, "stuff_err");
    step(LJ, D1, "after_serr");
    idle(LK, "idle_b");

    // Valid EOP, then a K decodes as 0
    step(L0, NONE, "eop_se0a");
    step(L0, NONE, "eop_se0b");
    step(LJ, EOP, "eop");
    step(LK, D0, "post_eop");

    // Short SE0 and SE0 followed by K
    step(L0, NONE, "short_se0");
    step(LJ, SE0E, "short_eop");
    step(L0, NONE, "se0_k_a");
    step(LK, SE0E, "se0_k");
    step(LK, D1, "post_se0_k");

    // SE1 leaves decode state untouched, in DATA and in SE0_RUN
    step(L1, SE1E, "se1_data");
    step(LK, D1, "post_se1");
    step(LJ, D0, "post_se1_j");
    step(L0, NONE, "se1_run_a");
    step(L1, SE1E, "se1_run");
    step(L0, NONE, "se1_run_b");
    step(LJ, EOP, "se1_run_eop");

    // Asynchronous reset with ones_cnt=5 while d_valid is high
    for (int i = 0; i < 5; i++) step(LJ, D1, $sformatf("pre_rst%0d", i));
    rst = 1'b1;
    #1;
    chk("fs_async_rst", fs_obs, NONE);
    chk("ls_async_rst", ls_obs, NONE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(LJ, D1, $sformatf("post_rst%0d", i));
    step(LJ, SERR, "post_rst_serr");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
